// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding and frame helpers for the PS/2
// keystroke transmitter.
package ps2_pkg;

  // Prefix byte sent between the two copies of a make code.
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  // Byte index of the final make code in a keystroke (code, F0, code).
  localparam logic [1:0] LAST_BYTE = 2'd2;

  // Raw encodings kept as plain constants so they stay usable from
  // older tools and from scripts that read the netlist.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FRAME = ST_FRAME,
    GAP   = ST_GAP
  } state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  // Full frame, LSB transmitted first: {stop, parity, data, start}.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data, 1'b0};
  endfunction

endpackage

// File: rtl/ascii2ps2_tx_ascii2key.sv
// ASCII to PS/2 set-2 make code lookup. This is the exact inverse of the
// scan-code decoder table; anything not in that table is reported invalid
// with a zero code.
module ascii2key (
  input  logic [7:0] ascii_i,
  output logic       valid_o,
  output logic [7:0] code_o
);

  // Pure lookup; default covers every unmapped character ('9', lowercase, ...).
  always_comb begin
    valid_o = 1'b1;
    code_o  = 8'h00;
    case (ascii_i)
      8'h30: code_o = 8'h45;  // '0'
      8'h31: code_o = 8'h16;
      8'h32: code_o = 8'h1E;
      8'h33: code_o = 8'h26;
      8'h34: code_o = 8'h25;
      8'h35: code_o = 8'h2E;
      8'h36: code_o = 8'h36;
      8'h37: code_o = 8'h3D;
      8'h38: code_o = 8'h3E;  // '8'
      8'h41: code_o = 8'h1C;  // 'A'
      8'h42: code_o = 8'h32;
      8'h43: code_o = 8'h21;
      8'h44: code_o = 8'h23;
      8'h45: code_o = 8'h24;
      8'h46: code_o = 8'h2B;
      8'h47: code_o = 8'h34;
      8'h48: code_o = 8'h33;
      8'h49: code_o = 8'h43;
      8'h4A: code_o = 8'h3B;
      8'h4B: code_o = 8'h42;
      8'h4C: code_o = 8'h4B;
      8'h4D: code_o = 8'h3A;
      8'h4E: code_o = 8'h31;
      8'h4F: code_o = 8'h44;
      8'h50: code_o = 8'h4D;
      8'h51: code_o = 8'h15;
      8'h52: code_o = 8'h2D;
      8'h53: code_o = 8'h1B;
      8'h54: code_o = 8'h2C;
      8'h55: code_o = 8'h3C;
      8'h56: code_o = 8'h2A;
      8'h57: code_o = 8'h1D;
      8'h58: code_o = 8'h22;
      8'h59: code_o = 8'h35;
      8'h5A: code_o = 8'h1A;  // 'Z'
      8'h20: code_o = 8'h29;  // space
      8'h0D: code_o = 8'h5A;  // enter
      8'h08: code_o = 8'h66;  // backspace
      default: begin
        valid_o = 1'b0;
        code_o  = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/ascii2ps2_tx.sv
// PS/2 device-side keystroke transmitter. One accepted character becomes
// three 11-bit frames (make, F0, make), each followed by an idle-high gap.
// ps2_clk/ps2_data are push-pull levels; open-drain conversion happens
// at the chip top.
module ascii2ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF   = 2500,  // system cycles per PS/2 half-period, 1..65535
  parameter int GAP_CYCLES = 5000   // idle-high cycles after each frame, 1..65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       err,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam logic [15:0] HALF_LAST = 16'(CLK_HALF - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [15:0]             half_cnt_q, half_cnt_d;
  logic [15:0]             gap_cnt_q, gap_cnt_d;
  logic [3:0]              bit_idx_q, bit_idx_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [7:0]              code_q, code_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    phase_q, phase_d;   // 1 = clock-high half of a bit
  logic                    err_q, err_d;

  logic                    key_valid;
  logic [7:0]              key_code;

  ascii2key u_ascii2key (
    .ascii_i (ascii_in),
    .valid_o (key_valid),
    .code_o  (key_code)
  );

  // Next-state logic: FSM plus the half-period, bit, gap and byte counters.
  // Data only advances on the low-to-high clock transition, so ps2_data is
  // stable for the whole low phase in which the host samples.
  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    code_d     = code_q;
    shift_d    = shift_q;
    phase_d    = phase_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (key_valid) begin
            code_d     = key_code;
            shift_d    = build_frame(key_code);
            byte_idx_d = 2'd0;
            bit_idx_d  = 4'd0;
            half_cnt_d = 16'd0;
            phase_d    = 1'b1;
            state_d    = FRAME;
          end else begin
            // Unmapped character is consumed and dropped.
            err_d = 1'b1;
          end
        end
      end

      FRAME: begin
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = 16'd0;
          if (phase_q) begin
            phase_d = 1'b0;
          end else begin
            phase_d = 1'b1;
            if (bit_idx_q == LAST_BIT) begin
              // Low phase of the stop bit just ended.
              gap_cnt_d = 16'd0;
              state_d   = GAP;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
              shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + 16'd1;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 16'd0;
          if (byte_idx_q < LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = build_frame((byte_idx_q == 2'd0) ? BREAK_CODE : code_q);
            bit_idx_d  = 4'd0;
            half_cnt_d = 16'd0;
            phase_d    = 1'b1;
            state_d    = FRAME;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any partial frame immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      half_cnt_q <= 16'd0;
      gap_cnt_q  <= 16'd0;
      bit_idx_q  <= 4'd0;
      byte_idx_q <= 2'd0;
      code_q     <= 8'h00;
      shift_q    <= '1;
      phase_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      code_q     <= code_d;
      shift_q    <= shift_d;
      phase_q    <= phase_d;
      err_q      <= err_d;
    end
  end

  // Outputs decode straight from registers; lines sit high outside frames.
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    err      = err_q;
    ps2_clk  = (state_q == FRAME) ? phase_q    : 1'b1;
    ps2_data = (state_q == FRAME) ? shift_q[0] : 1'b1;
  end

endmodule
